// File: rtl/seq_add_pipe_pkg.sv
// seq_add_pipe_pkg: shared types for the seq_add_pipe_stage slice.
//   state_e  - occupancy of the two-entry result buffer (EMPTY / ONE / FULL)
//   entry_t  - packed {carry, sum} result word at the default operand width
//   ENTRY_W  - operand width entry_t is built for
package seq_add_pipe_pkg;

  localparam int unsigned ENTRY_W = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic               carry;
    logic [ENTRY_W-1:0] sum;
  } entry_t;

endpackage

// File: rtl/seq_add_pipe_entry.sv
// seq_add_pipe_entry: combinational W-bit add producing one result entry.
// Build option: SEQ_ADD_PIPE_SAT_EN
//   undefined - sum wraps modulo 2^W, carry = bit W of a + b
//   defined   - sum saturates to all ones on overflow, carry flags saturation
// Ports:
//   a, b   in  [W-1:0]  operands
//   sum    out [W-1:0]  result word
//   carry  out          carry-out / saturation flag
// The {carry, sum} pair has the same bit layout as seq_add_pipe_pkg::entry_t.
module seq_add_pipe_entry #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W:0] full_sum;

  always_comb begin
    full_sum = {1'b0, a} + {1'b0, b};
`ifdef SEQ_ADD_PIPE_SAT_EN
    if (full_sum[W]) begin
      sum   = '1;
      carry = 1'b1;
    end else begin
      sum   = full_sum[W-1:0];
      carry = 1'b0;
    end
`else
    sum   = full_sum[W-1:0];
    carry = full_sum[W];
`endif
  end

endmodule

// File: rtl/seq_add_pipe_stage.sv
// seq_add_pipe_stage: registered adder stage with a two-entry skid buffer
// (main + skid) behind valid/ready, plus a delivered-result counter.
// Build option: SEQ_ADD_PIPE_SAT_EN selects saturating add (see seq_add_pipe_entry).
// Ports:
//   clk        in            posedge clock
//   rst        in            synchronous active-high reset
//   in_valid   in            upstream presents a, b
//   in_ready   out           stage can accept (buffer not FULL)
//   a, b       in  [W-1:0]   operands
//   out_valid  out           main entry holds a result
//   out_ready  in            downstream accepts the result
//   out_sum    out [W-1:0]   sum of the main entry
//   out_carry  out           carry of the main entry
//   out_cnt    out [CW-1:0]  results delivered, modulo 2^CW
module seq_add_pipe_stage
  import seq_add_pipe_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_sum,
  output logic          out_carry,
  output logic [CW-1:0] out_cnt
);

  state_e        state_q, state_d;
  // Entries are held as separate carry/sum registers so any W works.
  logic [W-1:0]  main_sum_q, main_sum_d;
  logic          main_carry_q, main_carry_d;
  logic [W-1:0]  skid_sum_q, skid_sum_d;
  logic          skid_carry_q, skid_carry_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W-1:0]  new_sum;
  logic          new_carry;
  logic          accept;
  logic          deliver;

  seq_add_pipe_entry #(
    .W (W)
  ) u_entry (
    .a     (a),
    .b     (b),
    .sum   (new_sum),
    .carry (new_carry)
  );

  // Handshake outputs decode registered state only: no out_ready -> in_ready path.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_sum   = main_sum_q;
  assign out_carry = main_carry_q;
  assign out_cnt   = cnt_q;

  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

  always_comb begin
    state_d      = state_q;
    main_sum_d   = main_sum_q;
    main_carry_d = main_carry_q;
    skid_sum_d   = skid_sum_q;
    skid_carry_d = skid_carry_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          main_sum_d   = new_sum;
          main_carry_d = new_carry;
          state_d      = ONE;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          main_sum_d   = new_sum;
          main_carry_d = new_carry;
        end else if (accept) begin
          skid_sum_d   = new_sum;
          skid_carry_d = new_carry;
          state_d      = FULL;
        end else if (deliver) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (deliver) begin
          main_sum_d   = skid_sum_q;
          main_carry_d = skid_carry_q;
          state_d      = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (deliver) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      main_sum_q   <= '0;
      main_carry_q <= 1'b0;
      skid_sum_q   <= '0;
      skid_carry_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      main_sum_q   <= main_sum_d;
      main_carry_q <= main_carry_d;
      skid_sum_q   <= skid_sum_d;
      skid_carry_q <= skid_carry_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule
